// File: rtl/stream_pipe_fifo_pkg.sv
// Shared helpers for stream_pipe_fifo: level-counter width and parameter legality.
package stream_pkg;

    function automatic int unsigned calc_l_width(input int unsigned n_stages,
                                                 input int unsigned a_width);
        return $clog2(n_stages + (1 << a_width) + 1);
    endfunction

    function automatic bit params_legal(input int unsigned d_width,
                                        input int unsigned a_width,
                                        input int unsigned n_stages,
                                        input int unsigned af_thresh);
        return (d_width >= 1) && (a_width >= 1) && (n_stages <= 8) &&
               (af_thresh >= 1) && (af_thresh <= (1 << a_width));
    endfunction

endpackage

// File: rtl/stream_pipe_fifo_if.sv
// Valid/ready stream bundle; master drives data/valid, slave drives ready.
interface stream_pipe_fifo_if #(
    parameter int unsigned D_WIDTH = 6
) ();
    logic [D_WIDTH-1:0] data;
    logic               valid;
    logic               ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/stream_pipe_fifo_reg_slice.sv
// One full-throughput valid/ready register stage with synchronous flush.
module stream_reg_slice #(
    parameter int unsigned D_WIDTH = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [D_WIDTH-1:0] in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [D_WIDTH-1:0] out_data,
    input  logic               out_ready
);
    logic               valid_q, valid_d;
    logic [D_WIDTH-1:0] data_q, data_d;

    always_comb begin
        in_ready = !valid_q || out_ready;
        valid_d  = valid_q;
        data_d   = data_q;
        if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) data_d = in_data;
        end
        if (flush) valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) valid_q <= 1'b0;
        else     valid_q <= valid_d;
        data_q <= data_d;
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
endmodule

// File: rtl/stream_pipe_fifo.sv
// Register-stage chain feeding a power-of-two FIFO, with flush, level and almost-full.
module stream_pipe_fifo
    import stream_pkg::*;
#(
    parameter  int unsigned D_WIDTH   = 6,
    parameter  int unsigned A_WIDTH   = 2,
    parameter  int unsigned N_STAGES  = 4,
    parameter  int unsigned AF_THRESH = 3,
    localparam int unsigned L_WIDTH   = calc_l_width(N_STAGES, A_WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    stream_pipe_fifo_if.slave  up,
    stream_pipe_fifo_if.master down,
    output logic [L_WIDTH-1:0] level,
    output logic               almost_full
);
    localparam int unsigned DEPTH = 1 << A_WIDTH;

    if (!params_legal(D_WIDTH, A_WIDTH, N_STAGES, AF_THRESH)) begin : g_param_check
        $error("stream_pipe_fifo: illegal parameter combination");
    end

    // Index 0 is the upstream port; index N_STAGES feeds the FIFO.
    logic [N_STAGES:0]  stg_valid;
    logic [N_STAGES:0]  stg_ready;
    logic [D_WIDTH-1:0] stg_data [0:N_STAGES];

    logic [D_WIDTH-1:0] mem_q [DEPTH];
    logic [A_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [A_WIDTH:0]   count_q, count_d;
    logic               full, empty, wr_en, rd_en;

    assign stg_valid[0] = up.valid;
    assign stg_data[0]  = up.data;
    assign up.ready     = stg_ready[0] && !flush && !rst;

    for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
        stream_reg_slice #(.D_WIDTH(D_WIDTH)) u_slice (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_valid  (stg_valid[k]),
            .in_data   (stg_data[k]),
            .in_ready  (stg_ready[k]),
            .out_valid (stg_valid[k+1]),
            .out_data  (stg_data[k+1]),
            .out_ready (stg_ready[k+1])
        );
    end

    assign full                = (count_q == DEPTH[A_WIDTH:0]);
    assign empty               = (count_q == '0);
    assign stg_ready[N_STAGES] = !full;
    // No write-through when full: a same-cycle pop frees the slot only next edge.
    assign wr_en               = stg_valid[N_STAGES] && !full;
    assign rd_en               = !empty && down.ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= stg_data[N_STAGES];
    end

    assign down.data  = mem_q[rd_ptr_q];
    assign down.valid = !empty && !flush;

    // Shift drops the upstream valid so only held stage beats are counted.
    assign level       = L_WIDTH'(count_q) + L_WIDTH'($countones(stg_valid >> 1));
    assign almost_full = (count_q >= AF_THRESH[A_WIDTH:0]);
endmodule

// File: tb/tb_stream_pipe_fifo.sv
// Directed bench for stream_pipe_fifo: default build plus an N_STAGES=0, A_WIDTH=1 build.
module tb_stream_pipe_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic flush_b;
    logic [3:0] a_level;
    logic       a_af;
    logic [1:0] b_level;
    logic       b_af;
    int checks = 0;
    int failures = 0;
    logic [5:0] qa[$];
    logic [5:0] qb[$];

    always #5 clk = ~clk;
    assign flush_b = 1'b0;

    stream_pipe_fifo_if #(.D_WIDTH(6)) a_up ();
    stream_pipe_fifo_if #(.D_WIDTH(6)) a_dn ();
    stream_pipe_fifo_if #(.D_WIDTH(6)) b_up ();
    stream_pipe_fifo_if #(.D_WIDTH(6)) b_dn ();

    stream_pipe_fifo #(.D_WIDTH(6), .A_WIDTH(2), .N_STAGES(4), .AF_THRESH(3)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .up(a_up), .down(a_dn),
        .level(a_level), .almost_full(a_af)
    );

    stream_pipe_fifo #(.D_WIDTH(6), .A_WIDTH(1), .N_STAGES(0), .AF_THRESH(2)) dut_b (
        .clk(clk), .rst(rst), .flush(flush_b), .up(b_up), .down(b_dn),
        .level(b_level), .almost_full(b_af)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: sampled mid-cycle, transfers happen at the following edge.
    always @(negedge clk) begin
        if (rst || flush) qa.delete();
        else begin
            if (a_dn.valid && a_dn.ready) begin
                checks++;
                assert (qa.size() > 0) else begin
                    failures++;
                    $error("FAIL a_sb_underflow observed=0x%0h expected=queued beat", a_dn.data);
                end
                if (qa.size() > 0) chk("a_sb_data", a_dn.data, qa.pop_front());
            end
            if (a_up.valid && a_up.ready) qa.push_back(a_up.data);
        end
    end

    always @(negedge clk) begin
        if (rst) qb.delete();
        else begin
            if (b_dn.valid && b_dn.ready) begin
                checks++;
                assert (qb.size() > 0) else begin
                    failures++;
                    $error("FAIL b_sb_underflow observed=0x%0h expected=queued beat", b_dn.data);
                end
                if (qb.size() > 0) chk("b_sb_data", b_dn.data, qb.pop_front());
            end
            if (b_up.valid && b_up.ready) qb.push_back(b_up.data);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic drain_a();
        a_up.valid = 1'b0;
        a_dn.ready = 1'b1;
        for (int i = 0; i < 40 && a_level != 0; i++) step();
        chk("a_drain_level", a_level, 0);
        chk("a_drain_sb_empty", qa.size(), 0);
    endtask

    task automatic six_then_clear(input bit use_rst);
        a_dn.ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a_up.data = 6'(8'h20 + i);
            a_up.valid = 1'b1;
            step();
        end
        chk("clr_pre_level", a_level, 6);
        if (use_rst) rst = 1'b1;
        else         flush = 1'b1;
        a_up.data = 6'h30;
        #1;
        chk("clr_up_ready", a_up.ready, 0);
        if (!use_rst) chk("clr_dv_gated", a_dn.valid, 0);
        step();
        rst = 1'b0;
        flush = 1'b0;
        a_up.valid = 1'b0;
        #1;
        chk("clr_level", a_level, 0);
        chk("clr_dv", a_dn.valid, 0);
        chk("clr_af", a_af, 0);
        a_dn.ready = 1'b1;
        a_up.data = 6'h15;
        a_up.valid = 1'b1;
        #1;
        chk("clr_reaccept", a_up.ready, 1);
        step();
        a_up.valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("clr_post_dv_low", a_dn.valid, 0);
            step();
        end
        chk("clr_post_dv", a_dn.valid, 1);
        chk("clr_post_data", a_dn.data, 6'h15);
        step();
        chk("clr_post_level", a_level, 0);
    endtask

    initial begin
        int nacc;
        int npop;
        a_up.valid = 1'b0; a_up.data = '0; a_dn.ready = 1'b0;
        b_up.valid = 1'b0; b_up.data = '0; b_dn.ready = 1'b0;

        // Reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_a_up_ready", a_up.ready, 1);
        chk("rst_a_dv", a_dn.valid, 0);
        chk("rst_a_level", a_level, 0);
        chk("rst_a_af", a_af, 0);
        chk("rst_b_up_ready", b_up.ready, 1);
        chk("rst_b_dv", b_dn.valid, 0);
        chk("rst_b_level", b_level, 0);

        // Latency through empty chain
        a_dn.ready = 1'b1;
        a_up.data = 6'h2A;
        a_up.valid = 1'b1;
        step();
        a_up.valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("lat_dv_low", a_dn.valid, 0);
            chk("lat_level", a_level, 1);
            step();
        end
        chk("lat_dv", a_dn.valid, 1);
        chk("lat_data", a_dn.data, 6'h2A);
        chk("lat_level_last", a_level, 1);
        step();
        chk("lat_dv_after", a_dn.valid, 0);
        chk("lat_level_after", a_level, 0);

        // Fill with back-pressure
        a_dn.ready = 1'b0;
        nacc = 0;
        for (int t = 0; t < 11; t++) begin
            a_up.data = 6'(nacc + 1);
            a_up.valid = (nacc < 10);
            #1;
            chk("fill_up_ready", a_up.ready, (t < 8));
            chk("fill_level", a_level, (t < 8) ? t : 8);
            chk("fill_af", a_af, (t >= 7));
            if (a_up.ready && a_up.valid) nacc++;
            step();
        end
        chk("fill_accepts", nacc, 8);

        // Full with a single pop: 4 -> 3 -> 4
        a_up.data = 6'd9;
        a_up.valid = 1'b1;
        a_dn.ready = 1'b1;
        #1;
        chk("pop_full_ur", a_up.ready, 0);
        chk("pop_full_dv", a_dn.valid, 1);
        step();
        a_dn.ready = 1'b0;
        #1;
        chk("pop_level7", a_level, 7);
        chk("pop_af", a_af, 1);
        chk("pop_ur", a_up.ready, 1);
        step();
        chk("pop_level8", a_level, 8);
        chk("pop_ur_full", a_up.ready, 0);

        // Sustained streaming from full: one bubble only
        a_dn.ready = 1'b1;
        nacc = 0;
        npop = 0;
        for (int i = 0; i < 10; i++) begin
            a_up.data = 6'(10 + nacc);
            a_up.valid = 1'b1;
            #1;
            if (a_up.ready) nacc++;
            if (a_dn.valid) npop++;
            step();
        end
        chk("stream_accepts", nacc, 9);
        chk("stream_pops", npop, 10);
        drain_a();
        chk("resume_up_ready", a_up.ready, 1);

        // Flush, then reset, mid-stream
        six_then_clear(1'b0);
        six_then_clear(1'b1);

        // N_STAGES=0, A_WIDTH=1 build
        b_dn.ready = 1'b1;
        b_up.data = 6'h3F;
        b_up.valid = 1'b1;
        step();
        b_up.valid = 1'b0;
        chk("b_lat_dv", b_dn.valid, 1);
        chk("b_lat_data", b_dn.data, 6'h3F);
        chk("b_lat_level", b_level, 1);
        step();
        chk("b_lat_dv_after", b_dn.valid, 0);
        chk("b_lat_level_after", b_level, 0);

        b_dn.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b_up.data = 6'(8'h10 + i);
            b_up.valid = 1'b1;
            #1;
            chk("b_cap_ur", b_up.ready, (i < 2));
            step();
        end
        b_up.valid = 1'b0;
        chk("b_cap_level", b_level, 2);
        chk("b_cap_af", b_af, 1);
        b_dn.ready = 1'b1;
        for (int i = 0; i < 10 && b_level != 0; i++) step();
        chk("b_drain_level", b_level, 0);
        chk("b_drain_sb_empty", qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stream_pipe_fifo.md
# stream_pipe_fifo

Parametrised successor to the fixed shift-register → logic → FIFO stream chain. It is a valid/ready stream buffer made of a configurable number of full-throughput register stages feeding a power-of-two FIFO. It adds a synchronous flush, an occupancy count and an almost-full flag. It sits between a stream producer and a consumer wherever elastic latency plus buffering is needed.

## Interface
- D_WIDTH, 6, data width in bits (≥1)
- A_WIDTH, 2, FIFO address width; FIFO depth = 2**A_WIDTH (A_WIDTH ≥1)
- N_STAGES, 4, number of pipeline register stages before the FIFO (0..8)
- AF_THRESH, 3, FIFO count at or above which almost_full asserts (1..2**A_WIDTH)
- Derived localparam L_WIDTH = $clog2(N_STAGES + 2**A_WIDTH + 1)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous discard of all held beats
- up_data  in  D_WIDTH  upstream data
- up_valid  in  1  upstream valid
- up_ready  out  1  upstream ready
- down_data  out  D_WIDTH  downstream data
- down_valid  out  1  downstream valid
- down_ready  in  1  downstream ready
- level  out  L_WIDTH  beats held in stages plus FIFO
- almost_full  out  1  FIFO count ≥ AF_THRESH

## Operation
- Transfer occurs on any interface when valid && ready are high at a rising edge.
- Each stage k holds one beat (valid_k, data_k). ready_k = !valid_k || ready_{k+1}, which is combinational back-pressure. The last stage's ready is FIFO not-full.
- up_ready = ready of stage 1 (or FIFO not-full when N_STAGES=0), forced 0 while flush or rst is high.
- FIFO: flop array, rd_ptr/wr_ptr of A_WIDTH bits wrapping naturally, count of A_WIDTH+1 bits.
  - Write when the last stage is valid and count < 2**A_WIDTH. There is no write-through when full, even if a pop occurs in the same cycle.
  - Read when count ≠ 0 and down_ready is high.
  - Simultaneous read and write leaves count unchanged.
  - down_data = mem[rd_ptr] (combinational read). down_valid = (count ≠ 0) && !flush.
  - There is no empty bypass.
- level = number of set stage valids + FIFO count, registered-consistent (derived from state, no extra cycle lag).
- almost_full = (count ≥ AF_THRESH).
- flush: at the next edge, clears all stage valids, both pointers and count. FIFO memory contents are not cleared. A beat presented with flush high is not accepted.
- rst has the same effect as flush and has priority.
- Data is never reordered, duplicated or dropped except by flush or rst.

## Timing
- Reset values: up_ready=1 (first cycle after reset release), down_valid=0, down_data=don't-care (compare only when valid), level=0, almost_full=0.
- Latency, empty chain: a beat accepted at edge t appears on down_valid/down_data after edge t+N_STAGES+1, i.e. N_STAGES+1 cycles. For N_STAGES=0 the latency is 1 cycle.
- Throughput: 1 beat/cycle sustained while the FIFO is not full.
  - With the FIFO full and down_ready held high, exactly one bubble is inserted, after which 1 beat/cycle resumes.
- Full chain capacity = N_STAGES + 2**A_WIDTH beats. up_ready deasserts combinationally once all stages are valid and the FIFO is full.
- up_ready depends combinationally on down_ready only through FIFO-full state; it does not depend on down_ready directly.
- level and almost_full update one edge after the causing transfer.

## Structure
- Package stream_pkg: function for L_WIDTH computation and the parameter legality checks (elaboration-time assertions on N_STAGES, A_WIDTH, AF_THRESH).
- Sub-module stream_reg_slice (one valid/ready register stage with flush), instantiated N_STAGES times in a generate loop.
- The FIFO and level logic live in the top.

## Test plan
Defaults (D_WIDTH=6, A_WIDTH=2, N_STAGES=4, AF_THRESH=3) unless stated.
- Reset: hold rst 2 cycles → up_ready=1, down_valid=0, level=0, almost_full=0.
- Latency: down_ready=1, single beat 0x2A accepted at edge 0 → down_valid=1 with 0x2A after edge 5 for exactly one cycle; level=1 during cycles 1..5.
- Fill/back-pressure: down_ready=0, offer 0x01..0x0A continuously → exactly 8 accepted, up_ready=0 after the 8th, level=8. almost_full rises when FIFO count reaches 3. Then down_ready=1 → output 0x01..0x08 in order, then further accepts resume.
- Full with pop: chain full, down_ready=1 one cycle → FIFO count 4→3, then 4 again next edge. Stream order is preserved and level goes 8→7→8 only if upstream refills.
- Flush mid-stream: 6 beats in flight, flush for 1 cycle with up_valid=1 → no accept that cycle, next cycle level=0, down_valid=0. Beat 0x15 offered afterwards emerges 5 cycles later. Same check with rst in place of flush.
- N_STAGES=0, A_WIDTH=1: beat 0x3F → down_valid one cycle later. Capacity is 2 and up_ready=0 on the third offer with down_ready=0.
